// File: rtl/dbg_cmd_engine.sv
// Debug command engine: decodes host debug bytes arriving from spi_slave,
// controls the core clock gating and debug LED, and serialises snapshots of
// PC / register / fetched-instruction state MSB-first over later transfers.
//
// Handshake: recv_ready is a one-cycle strobe qualifying recv_data. There is
// no back-pressure. Every register holds unless recv_ready=1, except in
// REG_LATCH, which advances on the next clk with or without a strobe. A strobe
// that arrives during REG_LATCH is dropped. busy reports any state other than
// IDLE, so it doubles as the visible FSM status.
module dbg_cmd_engine #(
    parameter int XLEN    = 64,
    parameter int FETCH_W = 112
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         recv_data,
    input  logic               recv_ready,
    output logic [7:0]         send_data,
    output logic               core_clk_enable,
    output logic               core_clk_pulse,
    output logic               led_buf,
    input  logic [XLEN-1:0]    reg_pc,
    input  logic [FETCH_W-1:0] fetch_instr,
    output logic [4:0]         reg_read_sel,
    input  logic [XLEN-1:0]    reg_read_data,
    output logic               busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ECHO      = 3'd1;
    localparam logic [2:0] S_READ_REG  = 3'd2;
    localparam logic [2:0] S_REG_LATCH = 3'd3;
    localparam logic [2:0] S_REPLYING  = 3'd4;

    localparam logic [4:0] XLEN_BYTES  = 5'(XLEN / 8);
    localparam logic [4:0] FETCH_BYTES = 5'(FETCH_W / 8);

    logic [2:0]   state;
    logic [127:0] reply_buf;
    logic [4:0]   reply_cnt;
    logic [7:0]   shamt;
    logic [127:0] reply_shifted;

    // Select the reply byte at the current count: the byte at bits
    // [count*8-1 -: 8] is moved down to bits [7:0].
    always_comb begin
        shamt         = {reply_cnt - 5'd1, 3'b000};
        reply_shifted = reply_buf >> shamt;
    end

    assign busy = (state != S_IDLE);

    // Command FSM with the reply buffer and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            send_data       <= 8'h00;
            core_clk_enable <= 1'b1;
            core_clk_pulse  <= 1'b0;
            led_buf         <= 1'b0;
            reg_read_sel    <= 5'd0;
            reply_buf       <= '0;
            reply_cnt       <= 5'd0;
        end else if (state == S_REG_LATCH) begin
            // Capture the register one cycle after the read index is
            // registered. The register-file read path is combinational.
            reply_buf <= 128'(reg_read_data);
            reply_cnt <= XLEN_BYTES;
            state     <= S_REPLYING;
        end else if (recv_ready) begin
            case (state)
                S_IDLE: begin
                    case (recv_data)
                        8'h00: send_data <= 8'h00;
                        8'h01: begin
                            send_data <= 8'h01;
                            state     <= S_ECHO;
                        end
                        8'h02: begin
                            led_buf   <= ~led_buf;
                            send_data <= 8'h00;
                        end
                        8'h03: begin
                            core_clk_enable <= 1'b1;
                            send_data       <= 8'h00;
                        end
                        8'h04: begin
                            core_clk_enable <= 1'b0;
                            send_data       <= 8'h00;
                        end
                        8'h05: begin
                            core_clk_pulse <= ~core_clk_pulse;
                            send_data      <= 8'h00;
                        end
                        8'h06: begin
                            reply_buf <= 128'(reg_pc);
                            reply_cnt <= XLEN_BYTES;
                            send_data <= 8'h00;
                            state     <= S_REPLYING;
                        end
                        8'h07: begin
                            send_data <= 8'h00;
                            state     <= S_READ_REG;
                        end
                        8'h09: begin
                            reply_buf <= 128'(fetch_instr);
                            reply_cnt <= FETCH_BYTES;
                            send_data <= 8'h00;
                            state     <= S_REPLYING;
                        end
                        8'hCC:   send_data <= 8'hCC;
                        // READ_FLASH (0x08) is refused because the CPU owns flash.
                        default: send_data <= 8'hFF;
                    endcase
                end
                S_ECHO: begin
                    send_data <= recv_data;
                    state     <= S_IDLE;
                end
                S_READ_REG: begin
                    reg_read_sel <= recv_data[4:0];
                    send_data    <= 8'h00;
                    state        <= S_REG_LATCH;
                end
                S_REPLYING: begin
                    send_data <= reply_shifted[7:0];
                    reply_cnt <= reply_cnt - 5'd1;
                    if (reply_cnt == 5'd1) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_cmd_engine.sv
// Directed bench for dbg_cmd_engine. Each task runs one scenario and compares
// the outputs against hand-computed values.
module tb_dbg_cmd_engine;

    logic         clk;
    logic         rst;
    logic [7:0]   recv_data;
    logic         recv_ready;
    logic [7:0]   send_data;
    logic         core_clk_enable;
    logic         core_clk_pulse;
    logic         led_buf;
    logic [63:0]  reg_pc;
    logic [111:0] fetch_instr;
    logic [4:0]   reg_read_sel;
    logic [63:0]  reg_read_data;
    logic         busy;

    int n_vec;
    int n_err;

    logic [63:0] regfile [32];

    dbg_cmd_engine #(.XLEN(64), .FETCH_W(112)) dut (
        .clk             (clk),
        .rst             (rst),
        .recv_data       (recv_data),
        .recv_ready      (recv_ready),
        .send_data       (send_data),
        .core_clk_enable (core_clk_enable),
        .core_clk_pulse  (core_clk_pulse),
        .led_buf         (led_buf),
        .reg_pc          (reg_pc),
        .fetch_instr     (fetch_instr),
        .reg_read_sel    (reg_read_sel),
        .reg_read_data   (reg_read_data),
        .busy            (busy)
    );

    // clock and combinational register-file model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb reg_read_data = regfile[reg_read_sel];

    // Drive one byte for a single clock edge. Outputs are valid at return
    // (sampled on the negedge after the capturing posedge).
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        recv_data  = b;
        recv_ready = 1'b1;
        @(negedge clk);
        recv_ready = 1'b0;
        recv_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (send_data !== 8'h00) begin n_err++; $display("FAIL reset_send: got %h want 00", send_data); end
        n_vec++;
        if (core_clk_enable !== 1'b1) begin n_err++; $display("FAIL reset_en: got %b want 1", core_clk_enable); end
        n_vec++;
        if (core_clk_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b want 0", core_clk_pulse); end
        n_vec++;
        if (led_buf !== 1'b0) begin n_err++; $display("FAIL reset_led: got %b want 0", led_buf); end
        n_vec++;
        if (reg_read_sel !== 5'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", reg_read_sel); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_echo();
        logic [7:0] bytes [3];
        logic [7:0] exp_s [3];
        logic       exp_b [3];
        bytes = '{8'h01, 8'h5A, 8'h00};
        exp_s = '{8'h01, 8'h5A, 8'h00};
        exp_b = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i]);
            n_vec++;
            if (send_data !== exp_s[i]) begin n_err++; $display("FAIL echo_send%0d: got %h want %h", i, send_data, exp_s[i]); end
            n_vec++;
            if (busy !== exp_b[i]) begin n_err++; $display("FAIL echo_busy%0d: got %b want %b", i, busy, exp_b[i]); end
        end
    endtask

    task automatic test_get_pc();
        logic [7:0] exp_pc [8];
        exp_pc = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        reg_pc = 64'h0123_4567_89AB_CDEF;
        send_byte(8'h06);
        n_vec++;
        if (send_data !== 8'h00) begin n_err++; $display("FAIL pc_cmd: got %h want 00", send_data); end
        reg_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h00);
            n_vec++;
            if (send_data !== exp_pc[i]) begin n_err++; $display("FAIL pc_byte%0d: got %h want %h", i, send_data, exp_pc[i]); end
            if (i < 7) begin
                n_vec++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL pc_busy%0d: got %b want 1", i, busy); end
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL pc_idle: got %b want 0", busy); end
    endtask

    task automatic test_get_reg();
        logic [7:0] exp_r [8];
        exp_r = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h11};
        send_byte(8'h07);
        n_vec++;
        if (send_data !== 8'h00) begin n_err++; $display("FAIL reg_cmd: got %h want 00", send_data); end
        send_byte(8'hE3);
        n_vec++;
        if (reg_read_sel !== 5'd3) begin n_err++; $display("FAIL reg_sel: got %0d want 3", reg_read_sel); end
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h00);
            n_vec++;
            if (send_data !== exp_r[i]) begin n_err++; $display("FAIL reg_byte%0d: got %h want %h", i, send_data, exp_r[i]); end
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reg_idle: got %b want 0", busy); end
    endtask

    // recv_ready held across the REG_LATCH edge: the second strobe is dropped.
    task automatic test_latch_drop();
        logic [7:0] exp_r [8];
        exp_r = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        send_byte(8'h07);
        @(negedge clk);
        recv_data  = 8'h05;
        recv_ready = 1'b1;
        @(negedge clk);
        recv_data  = 8'h77;
        @(negedge clk);
        recv_ready = 1'b0;
        recv_data  = 8'h00;
        n_vec++;
        if (send_data !== 8'h00) begin n_err++; $display("FAIL drop_send: got %h want 00", send_data); end
        n_vec++;
        if (reg_read_sel !== 5'd5) begin n_err++; $display("FAIL drop_sel: got %0d want 5", reg_read_sel); end
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h00);
            n_vec++;
            if (send_data !== exp_r[i]) begin n_err++; $display("FAIL drop_byte%0d: got %h want %h", i, send_data, exp_r[i]); end
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got %b want 0", busy); end
    endtask

    task automatic test_fetch();
        fetch_instr = 112'h0102030405060708090A0B0C0D0E;
        send_byte(8'h09);
        n_vec++;
        if (send_data !== 8'h00) begin n_err++; $display("FAIL fetch_cmd: got %h want 00", send_data); end
        for (int i = 0; i < 14; i++) begin
            if (i == 5) fetch_instr = '1;
            send_byte(8'hA5);
            n_vec++;
            if (send_data !== 8'(i + 1)) begin n_err++; $display("FAIL fetch_byte%0d: got %h want %h", i, send_data, 8'(i + 1)); end
        end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL fetch_idle: got %b want 0", busy); end
    endtask

    task automatic test_clock_led();
        logic [7:0] cmds  [5];
        logic       exp_e [5];
        logic       exp_p [5];
        logic       exp_l [5];
        cmds  = '{8'h04, 8'h05, 8'h05, 8'h03, 8'h02};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            send_byte(cmds[i]);
            n_vec++;
            if (core_clk_enable !== exp_e[i]) begin n_err++; $display("FAIL clk_en%0d: got %b want %b", i, core_clk_enable, exp_e[i]); end
            n_vec++;
            if (core_clk_pulse !== exp_p[i]) begin n_err++; $display("FAIL clk_pulse%0d: got %b want %b", i, core_clk_pulse, exp_p[i]); end
            n_vec++;
            if (led_buf !== exp_l[i]) begin n_err++; $display("FAIL led%0d: got %b want %b", i, led_buf, exp_l[i]); end
            n_vec++;
            if (send_data !== 8'h00) begin n_err++; $display("FAIL clk_send%0d: got %h want 00", i, send_data); end
        end
        // Stepping while the clock is already enabled still toggles the pulse.
        send_byte(8'h05);
        n_vec++;
        if (core_clk_pulse !== 1'b1) begin n_err++; $display("FAIL step_enabled: got %b want 1", core_clk_pulse); end
    endtask

    task automatic test_unknown();
        send_byte(8'h7F);
        n_vec++;
        if (send_data !== 8'hFF) begin n_err++; $display("FAIL unk_send: got %h want FF", send_data); end
        send_byte(8'hCC);
        n_vec++;
        if (send_data !== 8'hCC) begin n_err++; $display("FAIL cc_send: got %h want CC", send_data); end
        send_byte(8'h08);
        n_vec++;
        if (send_data !== 8'hFF) begin n_err++; $display("FAIL flash_send: got %h want FF", send_data); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL flash_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_pc [3];
        exp_pc = '{8'h01, 8'h23, 8'h45};
        reg_pc = 64'h0123_4567_89AB_CDEF;
        send_byte(8'h06);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00);
            n_vec++;
            if (send_data !== exp_pc[i]) begin n_err++; $display("FAIL mid_byte%0d: got %h want %h", i, send_data, exp_pc[i]); end
        end
        do_reset();
        n_vec++;
        if (send_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_send: got %h want 00", send_data); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_vec++;
        if (led_buf !== 1'b0 || core_clk_pulse !== 1'b0 || core_clk_enable !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_ctrl: got led=%b pulse=%b en=%b want 0 0 1", led_buf, core_clk_pulse, core_clk_enable);
        end
        send_byte(8'hCC);
        n_vec++;
        if (send_data !== 8'hCC) begin n_err++; $display("FAIL mid_cc: got %h want CC", send_data); end
        // A reset edge coinciding with a strobe wins over the strobe.
        @(negedge clk);
        rst        = 1'b0;
        recv_data  = 8'h01;
        recv_ready = 1'b1;
        @(negedge clk);
        rst        = 1'b1;
        recv_ready = 1'b0;
        recv_data  = 8'h00;
        n_vec++;
        if (send_data !== 8'h00 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_vs_ready: got send=%h busy=%b want 00 0", send_data, busy);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        recv_data   = 8'h00;
        recv_ready  = 1'b0;
        reg_pc      = '0;
        fetch_instr = '0;
        for (int i = 0; i < 32; i++) regfile[i] = {32'h1000_0000 + 32'(i), 32'h0};
        regfile[3]  = 64'hDEAD_BEEF_0000_0011;
        regfile[5]  = 64'h0000_0000_A55A_C33C;
        repeat (2) @(negedge clk);
        test_reset();
        test_echo();
        test_get_pc();
        test_get_reg();
        test_latch_drop();
        test_fetch();
        test_clock_led();
        test_unknown();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_cmd_engine.md
Name: dbg_cmd_engine

Overview:
- Debug command processor sitting directly downstream of spi_slave in the SPI SoC.
- Consumes one received byte per recv_ready pulse, decodes host debug commands, and drives the reply byte for the next SPI transfer.
- Drives the core clock-gating controls (enable/step) and the debug LED.
- Snapshots and serialises core state (PC, register file, fetched instruction) MSB-first over subsequent transfers.

Parameters:
- XLEN, 64, core register / PC width in bits; multiple of 8, at most 128.
- FETCH_W, 112, width of the fetched-instruction bundle (ALEN+ILEN); multiple of 8, at most 128.

Ports:
- clk  in  1  system clock, same domain as spi_slave ext_clk.
- rst  in  1  synchronous reset, active-low: rst=0 at a clk edge resets the block.
- recv_data  in  8  byte received from spi_slave; valid only while recv_ready=1.
- recv_ready  in  1  one-cycle pulse per received byte.
- send_data  out  8  registered reply byte shifted out on the next SPI transfer.
- core_clk_enable  out  1  free-run enable for the core BUFGCE.
- core_clk_pulse  out  1  toggles once per single-step request.
- led_buf  out  1  debug LED bit, ORed with GPIO LEDs outside this block.
- reg_pc  in  XLEN  current core PC.
- fetch_instr  in  FETCH_W  current fetch-stage bundle.
- reg_read_sel  out  5  registered register-file read index.
- reg_read_data  in  XLEN  register-file read data, combinational from reg_read_sel.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: send_data=0x00, core_clk_enable=1, core_clk_pulse=0, led_buf=0, reg_read_sel=0, state=IDLE, reply count=0.
- Clocking rule: all registers hold unless recv_ready=1. The single exception is REG_LATCH, which advances unconditionally.
- States: IDLE, ECHO, READ_REG, REG_LATCH, REPLYING.
- IDLE, on recv_ready, decodes recv_data:
  - 0x00 NOP: send 0x00.
  - 0x01 ECHO: send 0x01, go to ECHO.
  - 0x02 TOGGLE_LED: invert led_buf, send 0x00.
  - 0x03 ENABLE_CLOCK: core_clk_enable=1, send 0x00.
  - 0x04 DISABLE_CLOCK: core_clk_enable=0, send 0x00.
  - 0x05 STEP_CLOCK: invert core_clk_pulse, send 0x00. Applies even when the clock is already enabled.
  - 0x06 GET_PC: buf=reg_pc zero-extended to 128 bits, count=XLEN/8, send 0x00, go to REPLYING.
  - 0x07 GET_REG: send 0x00, go to READ_REG.
  - 0x08 READ_FLASH: send 0xFF (flash is owned by the CPU); state stays IDLE.
  - 0x09 GET_FETCHED_INSTR: buf=fetch_instr zero-extended, count=FETCH_W/8, send 0x00, go to REPLYING.
  - 0xCC: send 0xCC.
  - Any other value: send 0xFF.
- ECHO, on recv_ready: send_data=recv_data, go to IDLE.
- READ_REG, on recv_ready: reg_read_sel=recv_data[4:0] (upper 3 bits ignored), send 0x00, go to REG_LATCH.
- REG_LATCH, next clk regardless of recv_ready: buf=reg_read_data, count=XLEN/8, go to REPLYING.
  - A recv_ready arriving in this cycle is dropped; send_data is unchanged.
- REPLYING, on recv_ready:
  - send_data=buf[count*8-1 -: 8], count=count-1.
  - If count was 1, go to IDLE.
  - recv_data is not decoded; the host sends filler bytes.
- Reply timing: because spi_slave shifts send_data on the transfer after it is loaded, the host sees reply byte k on transfer k+1 after the command.
- Snapshot: the buffer is captured once at command time (REG_LATCH for GET_REG). Later changes in reg_pc, fetch_instr or reg_read_data do not alter an in-flight reply.
- Count width is 5 bits, sized for up to 16 bytes. Count never wraps; the IDLE transition occurs at count==1.
- Reset mid-operation (any state): all outputs return to reset values immediately at the edge, state=IDLE, and the partial reply is discarded.
- A reset edge coinciding with recv_ready is dominated by reset.

Test Plan:
- Reset then bytes 0x01, 0x5A, 0x00 -> send_data after each: 0x01, 0x5A, 0x00; busy high only between the 1st and 2nd byte.
- reg_pc=0x0123_4567_89AB_CDEF, bytes 0x06 then 8x 0x00 -> send_data 0x00, then 01,23,45,67,89,AB,CD,EF; state IDLE after the 9th byte.
- Bytes 0x07, 0xE3 with model regfile x3=0xDEAD_BEEF_0000_0011 -> reg_read_sel=3; the following 8 bytes return DE,AD,BE,EF,00,00,00,11.
- fetch_instr=112'h0102...0E, byte 0x09 then 14 fillers -> replies 0x01..0x0E in order; changing fetch_instr mid-reply has no effect on the sequence.
- Bytes 0x04, 0x05, 0x05, 0x03, 0x02 -> enable drops to 0; pulse toggles 0→1→0; enable returns to 1; led_buf=1.
- Unknown 0x7F -> 0xFF; 0x08 -> 0xFF with state IDLE; rst=0 asserted after the 3rd reply byte of GET_PC -> send_data=0x00, busy=0, and the next 0xCC returns 0xCC.
